// File: rtl/vga_store_pkg.sv
// vga_store_pkg: field positions, FSM state encoding and queue entry layout
// shared by the VGA store buffer and its bench.
`default_nettype none

package vga_store_pkg;

    localparam int COLOR_LSB = 24;
    localparam int X_LSB     = 8;
    localparam int Y_LSB     = 0;
    localparam int CLEAR_BIT = 31;

    // Entry fields are sized to the full store-word fields; the top trims them.
    localparam int ENTRY_COLOR_W = 3;
    localparam int ENTRY_XY_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [ENTRY_COLOR_W-1:0] color;
        logic [ENTRY_XY_W-1:0]    x;
        logic [ENTRY_XY_W-1:0]    y;
        logic                     clear;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/vga_store_buffer_if.sv
// vga_store_buffer_if: pipeline store port plus framebuffer write port.
`default_nettype none

interface vga_store_buffer_if #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3
);
    logic                       vga_we;
    logic [31:0]                vga_data;
    logic                       fb_grant;
    logic                       fb_we;
    logic [X_BITS+Y_BITS-1:0]   fb_addr;
    logic [COLOR_BITS-1:0]      fb_color;
    logic                       stall;
    logic                       empty;
    logic                       overflow;

    modport master (
        output vga_we, vga_data, fb_grant,
        input  fb_we, fb_addr, fb_color, stall, empty, overflow
    );

    modport slave (
        input  vga_we, vga_data, fb_grant,
        output fb_we, fb_addr, fb_color, stall, empty, overflow
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head, push/pop in the same cycle.
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_store_buffer.sv
// vga_store_buffer: queues pipeline pixel stores and drains them to the framebuffer
// only on granted cycles. Optional macro VGA_STORE_CLEAR_EN adds a full-screen clear.
`default_nettype none

module vga_store_buffer
    import vga_store_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vga_store_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int A_W   = X_BITS + Y_BITS;
`ifdef VGA_STORE_CLEAR_EN
    localparam logic [A_W-1:0] c_last_addr = '1;
`endif

    state_t           r_state;
    state_t           w_next_state;
    entry_t           w_in;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_fb_we;
    logic             w_empty;
    logic [A_W-1:0]   r_addr;
    logic [COLOR_BITS-1:0] r_color;
    logic             r_overflow;
    logic             w_unused;

    always_comb begin
        w_in       = '0;
        w_in.color = bus.vga_data[COLOR_LSB +: ENTRY_COLOR_W];
        w_in.x     = bus.vga_data[X_LSB +: ENTRY_XY_W];
        w_in.y     = bus.vga_data[Y_LSB +: ENTRY_XY_W];
`ifdef VGA_STORE_CLEAR_EN
        w_in.clear = bus.vga_data[CLEAR_BIT];
`endif
    end

    assign w_push   = bus.vga_we && !w_full;
    assign w_unused = ^{bus.vga_data[CLEAR_BIT], bus.vga_data, w_head, w_count};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_fifo_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, WRITE: begin
                if (w_pop) begin
`ifdef VGA_STORE_CLEAR_EN
                    if (w_head.clear) w_next_state = CLEAR;
                    else              w_next_state = WRITE;
`else
                    w_next_state = WRITE;
`endif
                end else begin
                    w_next_state = IDLE;
                end
            end
`ifdef VGA_STORE_CLEAR_EN
            CLEAR: begin
                if (bus.fb_grant && (r_addr == c_last_addr)) w_next_state = IDLE;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop   = 1'b0;
        w_fb_we = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = !w_fifo_empty && bus.fb_grant;
            end
            WRITE: begin
                w_fb_we = 1'b1;
                w_pop   = !w_fifo_empty && bus.fb_grant;
            end
`ifdef VGA_STORE_CLEAR_EN
            CLEAR: begin
                w_fb_we = bus.fb_grant;
            end
`endif
            default: begin
                w_pop   = 1'b0;
                w_fb_we = 1'b0;
            end
        endcase
        w_empty = (w_count == '0) && (r_state == IDLE);
    end

    // During a clear sweep r_addr doubles as the sweep address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_color    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.vga_we && w_full) r_overflow <= 1'b1;
            if (w_pop) begin
                r_color <= w_head.color[COLOR_BITS-1:0];
                r_addr  <= w_head.clear ? '0
                                        : {w_head.y[Y_BITS-1:0], w_head.x[X_BITS-1:0]};
            end
`ifdef VGA_STORE_CLEAR_EN
            else if ((r_state == CLEAR) && bus.fb_grant && (r_addr != c_last_addr)) begin
                r_addr <= r_addr + 1'b1;
            end
`endif
        end
    end

    assign bus.fb_we    = w_fb_we;
    assign bus.fb_addr  = r_addr;
    assign bus.fb_color = r_color;
    assign bus.stall    = w_full;
    assign bus.empty    = w_empty;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vga_store_buffer.sv
// tb_vga_store_buffer: directed bench for vga_store_buffer; framebuffer writes
// are captured on the falling edge and compared against hand-computed lists.
`default_nettype none

module tb_vga_store_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [17:0] wr_q [$];
    int          wr_cyc [$];

    vga_store_buffer_if #(.X_BITS(8), .Y_BITS(7), .COLOR_BITS(3)) bus_if ();

    vga_store_buffer #(
        .FIFO_DEPTH (8),
        .X_BITS     (8),
        .Y_BITS     (7),
        .COLOR_BITS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_if.fb_we === 1'b1) begin
            wr_q.push_back({bus_if.fb_color, bus_if.fb_addr});
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus_if.vga_we   = 1'b1;
        bus_if.vga_data = d;
        tick();
        bus_if.vga_we   = 1'b0;
    endtask

    // Expected framebuffer record {colour, y[6:0], x} for a store word.
    function automatic logic [17:0] rec_of(input logic [31:0] d);
        return {d[26:24], d[6:0], d[15:8]};
    endfunction

    function automatic logic [31:0] word_of(input int c, input int x, input int y);
        return (32'(c) << 24) | (32'(x) << 8) | 32'(y);
    endfunction

    logic [31:0] vec [8];
    int          errs;
    int          waited;

    initial begin
        bus_if.vga_we   = 1'b0;
        bus_if.vga_data = '0;
        bus_if.fb_grant = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check_eq("rst_fb_we",    bus_if.fb_we,    0);
        check_eq("rst_fb_addr",  bus_if.fb_addr,  0);
        check_eq("rst_fb_color", bus_if.fb_color, 0);
        check_eq("rst_stall",    bus_if.stall,    0);
        check_eq("rst_empty",    bus_if.empty,    1);
        check_eq("rst_overflow", bus_if.overflow, 0);
        rst = 1'b0;
        tick();

        // Single store, latency two edges after the push
        wr_q.delete();
        bus_if.fb_grant = 1'b1;
        push_word(32'h0300_1234);
        check_eq("t1_no_early_we", bus_if.fb_we, 0);
        check_eq("t1_not_empty",   bus_if.empty, 0);
        tick();
        check_eq("t1_we",    bus_if.fb_we,    1);
        check_eq("t1_addr",  bus_if.fb_addr,  15'h3412);
        check_eq("t1_color", bus_if.fb_color, 3);
        tick();
        check_eq("t1_we_done", bus_if.fb_we, 0);
        check_eq("t1_empty",   bus_if.empty, 1);
        tick();
        check_eq("t1_nwrites", wr_q.size(), 1);

        // Grant withheld: fill, overflow, then drain in order
        bus_if.fb_grant = 1'b0;
        tick();
        wr_q.delete(); wr_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            vec[i] = word_of(i, 16'h10 + i, i);
            push_word(vec[i]);
        end
        check_eq("t2_stall_full", bus_if.stall, 1);
        push_word(32'h0700_5555);
        check_eq("t2_overflow", bus_if.overflow, 1);
        check_eq("t2_no_writes", wr_q.size(), 0);
        // Grant rises while a push arrives at count=8: push is rejected
        bus_if.fb_grant = 1'b1;
        push_word(32'h0700_FFFF);
        for (int i = 0; i < 11; i++) tick();
        check_eq("t2_nwrites", wr_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("t2_wr%0d", i), 32'(wr_q[i]), 32'(rec_of(vec[i])));
        check_eq("t2_back_to_back", wr_cyc[7] - wr_cyc[0], 7);
        check_eq("t2_empty", bus_if.empty, 1);

        // Push and pop together at count=4 keeps order
        bus_if.fb_grant = 1'b0;
        tick();
        wr_q.delete();
        for (int i = 0; i < 6; i++) vec[i] = word_of(i + 1, 16'h40 + i, 16'h20 + i);
        for (int i = 0; i < 4; i++) push_word(vec[i]);
        bus_if.fb_grant = 1'b1;
        push_word(vec[4]);
        check_eq("t3_stall", bus_if.stall, 0);
        push_word(vec[5]);
        for (int i = 0; i < 8; i++) tick();
        check_eq("t3_nwrites", wr_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("t3_wr%0d", i), 32'(wr_q[i]), 32'(rec_of(vec[i])));

        // Grant toggled 1,0,0,1 mid-burst
        bus_if.fb_grant = 1'b0;
        tick();
        wr_q.delete();
        push_word(32'h0400_AAB4);
        push_word(32'h0500_0102);
        push_word(32'h0600_7F7F);
        bus_if.fb_grant = 1'b1;
        tick();
        bus_if.fb_grant = 1'b0;
        check_eq("t4_inflight_we", bus_if.fb_we, 1);
        tick();
        check_eq("t4_paused_we", bus_if.fb_we, 0);
        tick();
        check_eq("t4_paused_we2", bus_if.fb_we, 0);
        bus_if.fb_grant = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("t4_nwrites", wr_q.size(), 3);
        check_eq("t4_wr0", 32'(wr_q[0]), {14'd0, 3'd4, 15'h34AA});
        check_eq("t4_wr1", 32'(wr_q[1]), {14'd0, 3'd5, 15'h0201});
        check_eq("t4_wr2", 32'(wr_q[2]), {14'd0, 3'd6, 15'h7F7F});

        // Reset in the middle of a drain with entries still queued
        bus_if.fb_grant = 1'b0;
        for (int i = 0; i < 5; i++) push_word(word_of(i, i, i));
        bus_if.fb_grant = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_q.delete();
        check_eq("t5_fb_we",    bus_if.fb_we,    0);
        check_eq("t5_stall",    bus_if.stall,    0);
        check_eq("t5_empty",    bus_if.empty,    1);
        check_eq("t5_overflow", bus_if.overflow, 0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t5_no_stale", wr_q.size(), 0);
        push_word(32'h0200_0501);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t5_nwrites", wr_q.size(), 1);
        check_eq("t5_wr0", 32'(wr_q[0]), {14'd0, 3'd2, 15'h0105});

`ifdef VGA_STORE_CLEAR_EN
        // Clear sweep followed by a queued pixel store
        wr_q.delete();
        push_word(32'h8500_0000);
        push_word(32'h0100_0203);
        waited = 0;
        while (bus_if.empty !== 1'b1 && waited < 40000) begin
            tick();
            waited++;
        end
        check_eq("t6_timeout", (waited < 40000) ? 1 : 0, 1);
        tick(); tick();
        check_eq("t6_nwrites", wr_q.size(), 32769);
        errs = 0;
        for (int i = 0; i < 32768 && i < wr_q.size(); i++)
            if (wr_q[i] !== {3'd5, 15'(i)}) errs++;
        check_eq("t6_sweep_errs", errs, 0);
        check_eq("t6_pixel_after", 32'(wr_q[32768]), {14'd0, 3'd1, 15'h0302});
`else
        // Bit 31 is an ordinary data bit without the clear feature
        wr_q.delete();
        push_word(32'h8500_0000);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t6_nwrites", wr_q.size(), 1);
        check_eq("t6_wr0", 32'(wr_q[0]), {14'd0, 3'd5, 15'h0000});
        errs = 0;
        waited = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
